// File: rtl/md_issue_ctrl_pkg.sv
// Shared MD definitions: op codes, unit busy latencies and shadow FSM states.
package md_issue_ctrl_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_NONE  = 3'd7;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 4;

  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;

  // mult/multu/div/divu all have bit 2 clear
  function automatic logic is_mul_div(input logic [2:0] op);
    return ~op[2];
  endfunction
endpackage

// File: rtl/md_issue_ctrl_if.sv
// E-stage issue bus between the pipeline and the MD issue controller.
interface md_issue_ctrl_if;
  logic        e_valid;
  logic [2:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_uses_md;
  logic        m_excp;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        stall_d;
  logic        md_busy_shadow;
  logic        div0_flag;
  logic        proto_err;
  logic [31:0] stall_cnt;

  modport master (
    output e_valid, e_md_op, e_rs, e_rt, d_uses_md, m_excp,
    input  md_start, md_op, md_a, md_b, stall_d, md_busy_shadow,
           div0_flag, proto_err, stall_cnt
  );
  modport slave (
    input  e_valid, e_md_op, e_rs, e_rt, d_uses_md, m_excp,
    output md_start, md_op, md_a, md_b, stall_d, md_busy_shadow,
           div0_flag, proto_err, stall_cnt
  );
endinterface

// File: rtl/md_busy_shadow_cnt.sv
// Shadow of the MD unit busy interval: loads the op latency on start and
// counts down, dropping busy on the same edge the unit does.
module md_busy_shadow_cnt
  import md_issue_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);
  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: if (start) begin
        state_nxt = MD_RUN;
        cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end
      MD_RUN: if (cnt == CNT_W'(1)) begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == MD_RUN);
endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage MD issue controller: qualifies MD ops, drives the unit, and stalls
// D-stage MD-class instructions from a shadow of the unit's busy interval.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  md_issue_ctrl_if.slave     bus
);
  logic busy, issue_ok, is_div, div_zero, mt_op;

  assign is_div   = (bus.e_md_op == MD_DIV) || (bus.e_md_op == MD_DIVU);
  assign mt_op    = (bus.e_md_op == MD_MTHI) || (bus.e_md_op == MD_MTLO);
  assign div_zero = is_div && (bus.e_rt == 32'd0);
  assign issue_ok = bus.e_valid && !bus.m_excp && !busy;

  // start is combinational so the unit samples it on the same edge
  assign bus.md_start = issue_ok && is_mul_div(bus.e_md_op) && !div_zero;
  assign bus.md_op    = (issue_ok && (bus.md_start || mt_op)) ? bus.e_md_op : MD_NONE;
  assign bus.md_a     = bus.e_rs;
  assign bus.md_b     = bus.e_rt;
  assign bus.stall_d  = bus.d_uses_md && (bus.md_start || busy);
  assign bus.md_busy_shadow = busy;

  md_busy_shadow_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.md_start),
    .is_div (is_div),
    .busy   (busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.div0_flag <= 1'b0;
      bus.proto_err <= 1'b0;
      bus.stall_cnt <= '0;
    end else begin
      if (issue_ok && div_zero)
        bus.div0_flag <= 1'b1;
      if (bus.e_valid && (bus.e_md_op != MD_NONE) && busy)
        bus.proto_err <= 1'b1;
      if (bus.stall_d && (bus.stall_cnt != 32'hFFFF_FFFF))
        bus.stall_cnt <= bus.stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl.
module tb_md_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  md_issue_ctrl_if bus();

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_e();
    bus.e_valid = 1'b0;
    bus.e_md_op = 3'd7;
    bus.e_rs    = 32'd0;
    bus.e_rt    = 32'd0;
    bus.m_excp  = 1'b0;
  endtask

  task automatic do_reset();
    idle_e();
    bus.d_uses_md = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.e_valid = 1'b1;
    bus.e_md_op = op;
    bus.e_rs    = rs;
    bus.e_rt    = rt;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.md_start !== 1'b0 || bus.md_busy_shadow !== 1'b0 || bus.stall_d !== 1'b0) begin
      errors++; $display("FAIL reset_comb: start=%b busy=%b stall=%b expected 0 0 0",
                         bus.md_start, bus.md_busy_shadow, bus.stall_d);
    end
    checks++;
    if (bus.div0_flag !== 1'b0 || bus.proto_err !== 1'b0 || bus.stall_cnt !== 32'd0 || bus.md_op !== 3'd7) begin
      errors++; $display("FAIL reset_regs: div0=%b proto=%b cnt=%0d op=%0d expected 0 0 0 7",
                         bus.div0_flag, bus.proto_err, bus.stall_cnt, bus.md_op);
    end
  endtask

  task automatic test_mult();
    int ns, nb;
    do_reset();
    bus.d_uses_md = 1'b1;
    issue(3'd0, 32'd3, 32'hFFFF_FFFE);
    #1;
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_op !== 3'd0 || bus.md_a !== 32'd3 || bus.md_b !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mult_issue: start=%b op=%0d a=%h b=%h expected 1 0 00000003 fffffffe",
                         bus.md_start, bus.md_op, bus.md_a, bus.md_b);
    end
    ns = int'(bus.stall_d);
    nb = int'(bus.md_busy_shadow);
    @(negedge clk);
    idle_e();
    for (int i = 0; i < 12; i++) begin
      #1;
      ns += int'(bus.stall_d);
      nb += int'(bus.md_busy_shadow);
      @(negedge clk);
    end
    checks++;
    if (ns != 6 || nb != 5) begin
      errors++; $display("FAIL mult_intervals: stall=%0d busy=%0d expected 6 5", ns, nb);
    end
    checks++;
    if (bus.stall_cnt !== 32'd6) begin
      errors++; $display("FAIL mult_stall_cnt: got %0d expected 6", bus.stall_cnt);
    end
  endtask

  task automatic test_divu();
    int ns, nb;
    do_reset();
    bus.d_uses_md = 1'b1;
    issue(3'd3, 32'd100, 32'd7);
    #1;
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_op !== 3'd3) begin
      errors++; $display("FAIL divu_issue: start=%b op=%0d expected 1 3", bus.md_start, bus.md_op);
    end
    ns = int'(bus.stall_d);
    nb = 0;
    @(negedge clk);
    idle_e();
    for (int i = 0; i < 16; i++) begin
      #1;
      ns += int'(bus.stall_d);
      nb += int'(bus.md_busy_shadow);
      @(negedge clk);
    end
    checks++;
    if (ns != 11 || nb != 10 || bus.stall_cnt !== 32'd11) begin
      errors++; $display("FAIL divu_intervals: stall=%0d busy=%0d cnt=%0d expected 11 10 11",
                         ns, nb, bus.stall_cnt);
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    bus.d_uses_md = 1'b1;
    issue(3'd2, 32'd55, 32'd0);
    #1;
    checks++;
    if (bus.md_start !== 1'b0 || bus.md_op !== 3'd7 || bus.stall_d !== 1'b0) begin
      errors++; $display("FAIL div0_issue: start=%b op=%0d stall=%b expected 0 7 0",
                         bus.md_start, bus.md_op, bus.stall_d);
    end
    @(negedge clk);
    idle_e();
    #1;
    checks++;
    if (bus.div0_flag !== 1'b1 || bus.md_busy_shadow !== 1'b0 || bus.stall_d !== 1'b0) begin
      errors++; $display("FAIL div0_after: flag=%b busy=%b stall=%b expected 1 0 0",
                         bus.div0_flag, bus.md_busy_shadow, bus.stall_d);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.div0_flag !== 1'b1) begin
      errors++; $display("FAIL div0_sticky: flag=%b expected 1", bus.div0_flag);
    end
  endtask

  task automatic test_excp_block();
    do_reset();
    issue(3'd0, 32'd9, 32'd9);
    bus.m_excp = 1'b1;
    #1;
    checks++;
    if (bus.md_start !== 1'b0 || bus.md_op !== 3'd7) begin
      errors++; $display("FAIL excp_mult: start=%b op=%0d expected 0 7", bus.md_start, bus.md_op);
    end
    bus.e_md_op = 3'd4;
    #1;
    checks++;
    if (bus.md_op !== 3'd7) begin
      errors++; $display("FAIL excp_mthi: op=%0d expected 7", bus.md_op);
    end
    bus.m_excp = 1'b0;
    #1;
    checks++;
    if (bus.md_op !== 3'd4 || bus.md_start !== 1'b0) begin
      errors++; $display("FAIL mthi_issue: op=%0d start=%b expected 4 0", bus.md_op, bus.md_start);
    end
    bus.e_md_op = 3'd2;
    bus.m_excp  = 1'b1;
    @(negedge clk);
    idle_e();
    #1;
    checks++;
    if (bus.md_busy_shadow !== 1'b0 || bus.div0_flag !== 1'b0) begin
      errors++; $display("FAIL excp_no_state: busy=%b div0=%b expected 0 0",
                         bus.md_busy_shadow, bus.div0_flag);
    end
  endtask

  task automatic test_excp_in_run();
    int nb;
    do_reset();
    issue(3'd1, 32'd4, 32'd5);
    @(negedge clk);
    idle_e();
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      bus.m_excp = (i >= 2);
      #1;
      nb += int'(bus.md_busy_shadow);
      @(negedge clk);
    end
    bus.m_excp = 1'b0;
    checks++;
    if (nb != 5) begin
      errors++; $display("FAIL excp_in_run: busy=%0d expected 5", nb);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bus.d_uses_md = 1'b1;
    issue(3'd0, 32'd1, 32'd2);
    @(negedge clk);
    idle_e();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.md_busy_shadow !== 1'b1 || bus.stall_d !== 1'b1) begin
      errors++; $display("FAIL run3_pre: busy=%b stall=%b expected 1 1", bus.md_busy_shadow, bus.stall_d);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.md_busy_shadow !== 1'b0 || bus.stall_d !== 1'b0 || bus.stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_mid_run: busy=%b stall=%b cnt=%0d expected 0 0 0",
                         bus.md_busy_shadow, bus.stall_d, bus.stall_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_proto_err();
    do_reset();
    issue(3'd0, 32'd1, 32'd1);
    @(negedge clk);
    issue(3'd1, 32'd2, 32'd3);
    #1;
    checks++;
    if (bus.md_start !== 1'b0 || bus.md_op !== 3'd7 || bus.proto_err !== 1'b0) begin
      errors++; $display("FAIL proto_cycle: start=%b op=%0d perr=%b expected 0 7 0",
                         bus.md_start, bus.md_op, bus.proto_err);
    end
    @(negedge clk);
    idle_e();
    #1;
    checks++;
    if (bus.proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_err: got %b expected 1", bus.proto_err);
    end
  endtask

  task automatic test_back_to_back();
    int starts;
    do_reset();
    starts = 0;
    issue(3'd0, 32'd1, 32'd1);
    #1;
    starts += int'(bus.md_start);
    @(negedge clk);
    idle_e();
    for (int i = 0; i < 5; i++) @(negedge clk);
    issue(3'd1, 32'd6, 32'd7);
    #1;
    starts += int'(bus.md_start);
    checks++;
    if (starts != 2 || bus.md_op !== 3'd1) begin
      errors++; $display("FAIL back_to_back: starts=%0d op=%0d expected 2 1", starts, bus.md_op);
    end
    @(negedge clk);
    idle_e();
    #1;
    checks++;
    if (bus.md_busy_shadow !== 1'b1) begin
      errors++; $display("FAIL back_to_back_busy: got %b expected 1", bus.md_busy_shadow);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_e();
    bus.d_uses_md = 1'b0;
    test_reset();
    test_mult();
    test_divu();
    test_div_zero();
    test_excp_block();
    test_excp_in_run();
    test_reset_mid_run();
    test_proto_err();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
